can_bit_stuffer: RTL and testbench

Transmit-side CAN bit stuffer. It takes the unstuffed frame bit stream from the frame builder and drives the bus TX bit once per bit-time tick. After five consecutive equal bits inside the stuffed region, it inserts one complementary stuff bit. It is the counterpart of the receive-side destuffing block and uses the same 5-bit rule, so a stuff bit counts as the first bit of the next run.

---
 rtl/can_bit_stuffer_pkg.sv | 23 ++
 rtl/can_bit_stuffer_if.sv | 35 +++
 rtl/can_bit_stuffer_run_cnt.sv | 50 +++++
 rtl/can_bit_stuffer.sv | 134 +++++++++++++
 tb/tb_can_bit_stuffer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/can_bit_stuffer_pkg.sv
// Shared CAN bit-level constants and types for the stuffer and destuffer.
// Optional build macro: CAN_STUFF_CNT_EN adds a saturating stuff-bit counter.
package can_pkg;

  localparam int unsigned CAN_STUFF_LEN = 5;
  localparam logic        CAN_RECESSIVE = 1'b1;
  localparam logic        CAN_DOMINANT  = 1'b0;
  localparam int unsigned CAN_RUN_W     = 3;

  // Action taken on a bit-time tick, in priority order.
  typedef enum logic [2:0] {
    ActHold,   // no tick (or tick during reset): everything holds
    ActStuff,  // owed stuff bit goes out, nothing consumed
    ActData,   // stuffed-region bit consumed
    ActRaw,    // bit outside the stuffed region consumed
    ActIdle    // tick with no data: recessive idle bit
  } tick_act_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/can_bit_stuffer_if.sv
// Bit-stream handshake between the frame builder and the CAN bit stuffer.
// Optional build macro: CAN_STUFF_CNT_EN adds the stuff_cnt signal.
interface can_bit_stuffer_if;
  logic       tx_tick;
  logic       in_bit;
  logic       in_stf;
  logic       in_valid;
  logic       in_ready;
  logic       TX;
  logic       stuff_bit;
  logic       underrun;
`ifdef CAN_STUFF_CNT_EN
  logic [7:0] stuff_cnt;

  modport master (
    output tx_tick, in_bit, in_stf, in_valid,
    input  in_ready, TX, stuff_bit, underrun, stuff_cnt
  );

  modport slave (
    input  tx_tick, in_bit, in_stf, in_valid,
    output in_ready, TX, stuff_bit, underrun, stuff_cnt
  );
`else
  modport master (
    output tx_tick, in_bit, in_stf, in_valid,
    input  in_ready, TX, stuff_bit, underrun
  );

  modport slave (
    input  tx_tick, in_bit, in_stf, in_valid,
    output in_ready, TX, stuff_bit, underrun
  );
`endif
endinterface

// File: rtl/can_bit_stuffer_run_cnt.sv
// Equal-bit run counter plus last-bit register, shared with the destuffer.
// o_hit flags that pushing i_bit now would complete a run of STUFF_LEN.
module can_run_cnt
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic                 i_clr,
  input  logic                 i_bit,
  output logic                 o_last,
  output logic [CAN_RUN_W-1:0] o_run,
  output logic                 o_hit
);

  localparam logic [CAN_RUN_W-1:0] LenW = CAN_RUN_W'(STUFF_LEN);

  logic                 r_last;
  logic [CAN_RUN_W-1:0] r_run;
  logic [CAN_RUN_W-1:0] w_run_next;

  // Run length after pushing i_bit; a zero run means no run is open.
  always_comb begin
    w_run_next = CAN_RUN_W'(1);
    if (i_bit == r_last && r_run != '0) begin
      w_run_next = (r_run >= LenW) ? r_run : r_run + CAN_RUN_W'(1);
    end
  end

  assign o_hit  = (w_run_next == LenW);
  assign o_last = r_last;
  assign o_run  = r_run;

  // Push extends/restarts the run; clear closes it but still records the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= CAN_RECESSIVE;
      r_run  <= '0;
    end else if (i_push) begin
      r_last <= i_bit;
      r_run  <= w_run_next;
    end else if (i_clr) begin
      r_last <= i_bit;
      r_run  <= '0;
    end
  end

endmodule

// File: rtl/can_bit_stuffer.sv
// Transmit-side CAN bit stuffer: inserts a complementary bit after STUFF_LEN
// equal bits in the stuffed region; the stuff bit opens the next run.
// Optional build macro: CAN_STUFF_CNT_EN adds stuff_cnt (saturating at 255).
module can_bit_stuffer
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN
) (
  input logic               clk,
  input logic               reset,
  can_bit_stuffer_if.slave  io_bus
);

  tick_act_e            w_act;
  logic                 w_push;
  logic                 w_clr;
  logic                 w_cnt_bit;
  logic                 w_last;
  logic [CAN_RUN_W-1:0] w_run;
  logic                 w_hit;

  logic                 r_tx;
  logic                 r_stuff_bit;
  logic                 r_underrun;
  logic                 r_pending;

  // Decode the tick action; reset masks the tick entirely.
  always_comb begin
    w_act = ActHold;
    if (!reset && io_bus.tx_tick) begin
      if (r_pending) begin
        w_act = ActStuff;
      end else if (io_bus.in_valid) begin
        w_act = io_bus.in_stf ? ActData : ActRaw;
      end else begin
        w_act = ActIdle;
      end
    end
  end

  // Steer the run counter from the decoded action.
  always_comb begin
    w_push    = 1'b0;
    w_clr     = 1'b0;
    w_cnt_bit = CAN_RECESSIVE;
    unique case (w_act)
      ActStuff: begin
        w_push    = 1'b1;
        w_cnt_bit = ~w_last;
      end
      ActData: begin
        w_push    = 1'b1;
        w_cnt_bit = io_bus.in_bit;
      end
      ActRaw: begin
        w_clr     = 1'b1;
        w_cnt_bit = io_bus.in_bit;
      end
      ActIdle: begin
        w_clr     = 1'b1;
        w_cnt_bit = CAN_RECESSIVE;
      end
      default: ;
    endcase
  end

  can_run_cnt #(
    .STUFF_LEN (STUFF_LEN)
  ) u_run_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_clr  (w_clr),
    .i_bit  (w_cnt_bit),
    .o_last (w_last),
    .o_run  (w_run),
    .o_hit  (w_hit)
  );

  // Registered bus outputs and the owed-stuff flag; underrun is a 1-clk pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx        <= CAN_RECESSIVE;
      r_stuff_bit <= 1'b0;
      r_underrun  <= 1'b0;
      r_pending   <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      unique case (w_act)
        ActStuff: begin
          r_tx        <= ~w_last;
          r_stuff_bit <= 1'b1;
          r_pending   <= 1'b0;
        end
        ActData: begin
          r_tx        <= io_bus.in_bit;
          r_stuff_bit <= 1'b0;
          r_pending   <= w_hit;
        end
        ActRaw: begin
          r_tx        <= io_bus.in_bit;
          r_stuff_bit <= 1'b0;
        end
        ActIdle: begin
          r_tx        <= CAN_RECESSIVE;
          r_stuff_bit <= 1'b0;
          r_underrun  <= (w_run != '0);
        end
        default: ;
      endcase
    end
  end

  assign io_bus.in_ready  = io_bus.tx_tick & ~r_pending & ~reset;
  assign io_bus.TX        = r_tx;
  assign io_bus.stuff_bit = r_stuff_bit;
  assign io_bus.underrun  = r_underrun;

`ifdef CAN_STUFF_CNT_EN
  logic [7:0] r_stuff_cnt;

  // Count inserted stuff bits, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stuff_cnt <= 8'd0;
    end else if (w_act == ActStuff) begin
      r_stuff_cnt <= sat_inc8(r_stuff_cnt);
    end
  end

  assign io_bus.stuff_cnt = r_stuff_cnt;
`endif

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Self-checking bench for can_bit_stuffer: directed scenarios plus random
// frames, checked against a transmitted-history model of the stuffing rule.
module tb_can_bit_stuffer;
  localparam int SL = can_pkg::CAN_STUFF_LEN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  can_bit_stuffer_if bus ();

  can_bit_stuffer #(
    .STUFF_LEN (SL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: bits sent in the current stuffed segment (stuff bits included).
  bit hist[$];
  bit m_tx  = 1'b1;
  bit m_sb  = 1'b0;
  int m_cnt = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // A stuff bit is owed when the last SL transmitted bits of the segment agree.
  function automatic bit owed();
    if (hist.size() < SL) return 1'b0;
    for (int i = 1; i < SL; i++) begin
      if (hist[hist.size() - 1 - i] != hist[hist.size() - 1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_outs(input string tag, input bit exp_un);
    chk({tag, ".TX"}, bus.TX, m_tx);
    chk({tag, ".stuff_bit"}, bus.stuff_bit, m_sb);
    chk({tag, ".underrun"}, bus.underrun, exp_un);
`ifdef CAN_STUFF_CNT_EN
    chk({tag, ".stuff_cnt"}, bus.stuff_cnt, 8'(m_cnt));
`endif
  endtask

  task automatic tick(input logic v, input logic b, input logic s, output bit used);
    bit exp_un;
    @(negedge clk);
    bus.tx_tick  = 1'b1;
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.in_stf   = s;
    #1;
    chk("tick.in_ready", bus.in_ready, !owed());
    used   = 1'b0;
    exp_un = 1'b0;
    if (owed()) begin
      m_tx = !hist[hist.size() - 1];
      m_sb = 1'b1;
      hist.push_back(m_tx);
      if (m_cnt < 255) m_cnt++;
    end else if (v) begin
      used = 1'b1;
      m_tx = b;
      m_sb = 1'b0;
      if (s) hist.push_back(b);
      else hist.delete();
    end else begin
      m_tx   = 1'b1;
      m_sb   = 1'b0;
      exp_un = (hist.size() != 0);
      hist.delete();
    end
    while (hist.size() > SL) void'(hist.pop_front());
    @(posedge clk);
    #1;
    bus.tx_tick = 1'b0;
    check_outs("tick", exp_un);
  endtask

  // Clock with no tick: outputs hold and underrun has dropped.
  task automatic gap();
    @(negedge clk);
    bus.tx_tick  = 1'b0;
    bus.in_valid = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    check_outs("gap", 1'b0);
  endtask

  task automatic send(input logic b, input logic s);
    bit used = 1'b0;
    for (int k = 0; k < 3 && !used; k++) tick(1'b1, b, s, used);
    chk("send.consumed", used, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset        = 1'b1;
      bus.tx_tick  = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b0;
      bus.in_stf   = 1'b1;
      #1;
      chk("rst.in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
      #1;
      hist.delete();
      m_tx  = 1'b1;
      m_sb  = 1'b0;
      m_cnt = 0;
      check_outs("rst", 1'b0);
    end
    @(negedge clk);
    reset        = 1'b0;
    bus.tx_tick  = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bit u;
    int n_stuff;
    bus.tx_tick  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b1;
    bus.in_stf   = 1'b0;

    do_reset(3);

    // Dominant run of five, then a 1: stuff 1 precedes the data 1.
    n_stuff = 0;
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, u);
    chk("dom.stuff_tick_not_consumed", u, 1'b0);
    chk("dom.stuff_tx", bus.TX, 1'b1);
    chk("dom.stuff_flag", bus.stuff_bit, 1'b1);
    tick(1'b1, 1'b1, 1'b1, u);
    chk("dom.data_consumed", u, 1'b1);
    tick(1'b0, 1'b0, 1'b0, u);
    gap();

    // Stuff bit opens the next run: 0x5, 1x4 -> stuff 0 after four data 1s.
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, u);
    chk("run.stuff0_tx", bus.TX, 1'b0);
    chk("run.stuff0_flag", bus.stuff_bit, 1'b1);
    send(1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, u);

    // No stuffing outside the stuffed region.
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
    chk("raw.no_stuff", bus.stuff_bit, 1'b0);
    tick(1'b0, 1'b0, 1'b0, u);

    // Owed stuff bit still goes out when the next bit is outside the region.
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, u);

    // Underrun after three stuffed bits, pulse lasts one clock.
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, u);
    chk("und.pulse", bus.underrun, 1'b1);
    gap();
    gap();

    // Reset while a stuff bit is owed drops it.
    for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
    do_reset(1);
    tick(1'b0, 1'b0, 1'b0, u);
    chk("rstp.idle_tx", bus.TX, 1'b1);
    chk("rstp.no_stuff", bus.stuff_bit, 1'b0);

    // Random frames: stuffed prefix, unstuffed tail, random gaps and drop-outs.
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(8, 40);
      int reg_end = $urandom_range(4, len);
      logic b = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) b = ~b;
        send(b, (i < reg_end) ? 1'b1 : 1'b0);
        if ($urandom_range(0, 5) == 0) gap();
        if ($urandom_range(0, 30) == 0) tick(1'b0, 1'b0, 1'b0, u);
      end
      tick(1'b0, 1'b0, 1'b0, u);
      if ($urandom_range(0, 2) == 0) gap();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
